// File: rtl/uart_pkg.sv
// Shared types and helpers for the CDC outport UART transmitter.
package uart_pkg;

   // Transmit frame sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int UART_DATA_BITS = 8;

   // Clock cycles per UART bit (integer division, truncating).
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/cdc_uart_tx_if.sv
// Byte stream from the CDC outport into the UART transmitter.
// Handshake: a byte transfers on every rising clock edge where in_valid and
// in_accept are both high. in_accept depends only on registered state, never
// on in_valid; in_data is don't-care whenever in_valid is low.
import uart_pkg::*;

interface cdc_uart_tx_if;
   logic                      in_valid;
   logic [UART_DATA_BITS-1:0] in_data;
   logic                      in_accept;

   modport master (output in_valid, output in_data, input in_accept);
   modport slave  (input in_valid, input in_data, output in_accept);
endinterface

// File: rtl/byte_fifo.sv
// Synchronous FIFO with an explicit occupancy counter. DEPTH must be a power
// of two so the pointers wrap naturally. Read data is the head entry, visible
// combinationally so a pop can capture it in the same cycle.
module byte_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [LW-1:0]    o_level,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_level == LW'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_data    = r_mem[r_rd_ptr];
   assign o_level   = r_level;

   // Storage array; contents need no reset because level gates every read.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave the level unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/cdc_uart_tx.sv
// CDC outport byte sink: queues host bytes and serialises them as UART 8N1/8N2.
// The line and busy flags are registered one cycle behind the sequencer state,
// so a byte pushed at edge N is popped at N+1 and the start bit begins at N+2.
import uart_pkg::*;

module cdc_uart_tx #(
   parameter int CLK_HZ     = 60_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   cdc_uart_tx_if.slave                   in_if,
   input  logic                           tx_enable,
   output logic                           uart_tx,
   output logic                           busy,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output tx_state_t                      dbg_state
);

   localparam int CPB       = clks_per_bit(CLK_HZ, BAUD);
   localparam int STOP_CLKS = STOP_BITS * CPB;
   localparam int CW        = $clog2(STOP_CLKS);
   localparam int BW        = $clog2(UART_DATA_BITS);

   tx_state_t                 r_state;
   tx_state_t                 w_state_nxt;
   logic [CW-1:0]             r_cnt;
   logic [CW-1:0]             w_cnt_nxt;
   logic [BW-1:0]             r_bit;
   logic [BW-1:0]             w_bit_nxt;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [UART_DATA_BITS-1:0] w_shift_nxt;
   logic                      r_tx;
   logic                      w_tx_nxt;
   logic                      r_busy;
   logic                      w_pop;
   logic                      w_start_ok;
   logic [UART_DATA_BITS-1:0] w_head;
   logic                      w_full;
   logic                      w_empty;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (in_if.in_valid),
      .i_data  (in_if.in_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_level (fifo_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign in_if.in_accept = ~w_full;
   assign w_start_ok      = tx_enable & ~w_empty;
   assign uart_tx         = r_tx;
   assign busy            = r_busy;
   assign dbg_state       = r_state;

   // Next-state, baud/bit counters, shift register and pop request.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;
      w_tx_nxt    = 1'b1;
      case (r_state)
         IDLE: begin
            w_tx_nxt  = 1'b1;
            w_cnt_nxt = '0;
            if (w_start_ok) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_head;
               w_state_nxt = START;
            end
         end
         START: begin
            w_tx_nxt = 1'b0;
            if (r_cnt == CW'(CPB - 1)) begin
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               w_state_nxt = DATA;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         DATA: begin
            w_tx_nxt = r_shift[0];
            if (r_cnt == CW'(CPB - 1)) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = r_shift >> 1;
               if (r_bit == BW'(UART_DATA_BITS - 1)) begin
                  w_state_nxt = STOP;
               end else begin
                  w_bit_nxt = r_bit + BW'(1);
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         STOP: begin
            w_tx_nxt = 1'b1;
            if (r_cnt == CW'(STOP_CLKS - 1)) begin
               w_cnt_nxt = '0;
               if (w_start_ok) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_head;
                  w_state_nxt = START;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Sequencer registers plus the glitch-free line and busy flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= (r_state != IDLE);
      end
   end

endmodule

// File: tb/tb_cdc_uart_tx.sv
// Bench for cdc_uart_tx: directed scenarios plus a random soak. Bytes are
// queued as expected when accepted; a UART decoder pops and compares frames.
module tb_cdc_uart_tx;
   import uart_pkg::*;

   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD   = 100_000;
   localparam int DEPTH  = 16;

   // ---------------- clock / reset ----------------
   logic      clk       = 1'b0;
   logic      rst_n     = 1'b0;
   logic      tx_enable = 1'b0;
   logic      uart_tx;
   logic      busy;
   logic [4:0] fifo_level;
   tx_state_t dbg_state;

   cdc_uart_tx_if u_if ();

   always #5 clk = ~clk;

   cdc_uart_tx #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH),
      .STOP_BITS  (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_if      (u_if.slave),
      .tx_enable  (tx_enable),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .fifo_level (fifo_level),
      .dbg_state  (dbg_state)
   );

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         last_push_cyc = 0;
   logic [7:0] exp_q [$];
   bit         inv_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_byte(input logic [7:0] d);
      int n;
      n = 0;
      @(negedge clk);
      u_if.in_valid = 1'b1;
      u_if.in_data  = d;
      while (!u_if.in_accept && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!u_if.in_accept) begin
         total++;
         bad++;
         $display("FAIL push_timeout: byte 0x%0h not accepted within %0d cycles", d, n);
      end else begin
         last_push_cyc = cyc + 1;
         exp_q.push_back(d);
         @(posedge clk);
      end
   endtask

   task automatic idle_in();
      @(negedge clk);
      u_if.in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int bound);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(name, (exp_q.size() == 0 && !busy), 1);
   endtask

   // ---------------- UART monitor / scoreboard ----------------
   bit         mon_on = 1'b0;
   int         mon_cnt = 0;
   logic [7:0] mon_byte;
   int         mon_frames = 0;
   bit         gap_chk = 1'b0;
   bit         have_prev = 1'b0;
   int         prev_start = 0;
   int         gap_n = 0;
   logic [7:0] mon_exp;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_on  = 1'b0;
         mon_cnt = 0;
      end else if (!mon_on) begin
         if (uart_tx == 1'b0) begin
            mon_on  = 1'b1;
            mon_cnt = 0;
            if (gap_chk && have_prev) begin
               chk("frame_spacing", cyc - prev_start, 100);
               gap_n++;
            end
            prev_start = cyc;
            have_prev  = 1'b1;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt == 5) chk("start_bit", uart_tx, 0);
         if (mon_cnt >= 15 && mon_cnt <= 85 && ((mon_cnt - 15) % 10) == 0)
            mon_byte[(mon_cnt - 15) / 10] = uart_tx;
         if (mon_cnt == 95) begin
            chk("stop_bit", uart_tx, 1);
            mon_frames++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_frame: got 0x%0h with nothing queued", mon_byte);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("frame_byte", mon_byte, mon_exp);
            end
            mon_on = 1'b0;
         end
      end
   end

   // Continuous invariants on the input side.
   always @(negedge clk) begin
      if (rst_n && inv_on) begin
         chk("level_max", (fifo_level <= 5'd16), 1);
         chk("accept_vs_level", u_if.in_accept, (fifo_level != 5'd16));
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   int n0;
   int en_cyc;
   int acc16_cyc;
   int frames0;
   bit drv_done;

   initial begin
      u_if.in_valid = 1'b0;
      u_if.in_data  = 8'h00;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 1: reset state
      chk("rst_uart_tx", uart_tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_accept", u_if.in_accept, 1);
      chk("rst_state", dbg_state, IDLE);
      inv_on = 1'b1;

      // 2: single byte latency and busy timing
      tx_enable = 1'b1;
      push_byte(8'h55);
      n0 = last_push_cyc;
      idle_in();
      chk("t2_line_at_N", uart_tx, 1);
      @(negedge clk);
      chk("t2_line_at_N1", uart_tx, 1);
      @(negedge clk);
      chk("t2_line_at_N2", uart_tx, 0);
      chk("t2_busy_at_N2", busy, 1);
      while (cyc < n0 + 101) @(negedge clk);
      chk("t2_busy_at_N101", busy, 1);
      @(negedge clk);
      chk("t2_busy_at_N102", busy, 0);
      chk("t2_line_idle", uart_tx, 1);
      chk("t2_decoded", exp_q.size(), 0);

      // 3: fill while disabled, then back-to-back drain
      tx_enable = 1'b0;
      repeat (5) @(negedge clk);
      acc16_cyc = 0;
      en_cyc    = 0;
      gap_n     = 0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               push_byte(8'(i));
               if (i == 16) acc16_cyc = last_push_cyc;
            end
            idle_in();
         end
         begin
            for (int k = 0; k < 40 && fifo_level != 5'd16; k++) @(negedge clk);
            repeat (5) @(negedge clk);
            chk("t3_level_full", fifo_level, 16);
            chk("t3_accept_low", u_if.in_accept, 0);
            chk("t3_not_busy", busy, 0);
            gap_chk   = 1'b1;
            have_prev = 1'b0;
            tx_enable = 1'b1;
            en_cyc    = cyc;
         end
      join
      wait_drain("t3_drain", 3000);
      gap_chk = 1'b0;
      chk("t3_first_refill", acc16_cyc - en_cyc, 2);
      chk("t3_gap_count", gap_n, 19);

      // 4: disable mid-frame
      repeat (5) @(negedge clk);
      push_byte(8'hA1);
      n0 = last_push_cyc;
      push_byte(8'h3C);
      push_byte(8'hF0);
      idle_in();
      while (cyc < n0 + 45) @(negedge clk);
      tx_enable = 1'b0;
      chk("t4_busy_mid", busy, 1);
      for (int k = 0; k < 200 && busy; k++) @(negedge clk);
      chk("t4_frame_done", busy, 0);
      chk("t4_line_high", uart_tx, 1);
      chk("t4_level", fifo_level, 2);
      repeat (50) @(negedge clk);
      chk("t4_hold_busy", busy, 0);
      chk("t4_hold_level", fifo_level, 2);
      chk("t4_hold_line", uart_tx, 1);
      chk("t4_one_decoded", exp_q.size(), 2);
      tx_enable = 1'b1;
      wait_drain("t4_drain", 500);
      chk("t4_level_end", fifo_level, 0);

      // 5: reset mid data with five queued
      repeat (5) @(negedge clk);
      push_byte(8'h00);
      n0 = last_push_cyc;
      for (int i = 1; i <= 5; i++) push_byte(8'h10 + 8'(i));
      idle_in();
      while (cyc < n0 + 40) @(negedge clk);
      chk("t5_level_before", fifo_level, 5);
      chk("t5_line_low", uart_tx, 0);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("t5_async_line", uart_tx, 1);
      chk("t5_async_busy", busy, 0);
      chk("t5_async_level", fifo_level, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("t5_post_level", fifo_level, 0);
      chk("t5_post_busy", busy, 0);
      chk("t5_post_state", dbg_state, IDLE);
      repeat (200) @(negedge clk);
      chk("t5_quiet_line", uart_tx, 1);
      chk("t5_quiet_busy", busy, 0);

      // 6: random soak
      frames0  = mon_frames;
      drv_done = 1'b0;
      fork
         begin
            int gap;
            for (int i = 0; i < 500; i++) begin
               gap = $urandom_range(0, 3);
               if (gap > 0) begin
                  idle_in();
                  repeat (gap - 1) @(negedge clk);
               end
               push_byte(8'($urandom_range(0, 255)));
            end
            idle_in();
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               repeat ($urandom_range(300, 600)) @(negedge clk);
               tx_enable = 1'b0;
               repeat ($urandom_range(10, 40)) @(negedge clk);
               tx_enable = 1'b1;
            end
         end
      join
      tx_enable = 1'b1;
      wait_drain("t6_drain", 20000);
      chk("t6_frames", mon_frames - frames0, 500);
      chk("t6_level_end", fifo_level, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
